// File: rtl/program_counter_stack.sv
// Program counter with up/down count, absolute/relative branch and a
// return-address stack for call/ret, sharing one tri-state system bus.
//
// Ports:
//   clk        clock, all state changes on its rising edge
//   rst        asynchronous active-high reset
//   bus        WIDTH-bit shared bus, driven with pc when co=1, else Z
//   co         output enable of pc onto bus
//   ce         count enable, updown selects +1 (1) or -1 (0)
//   jmp        load pc from bus
//   rel        add signed bus value to pc
//   call       push pc+1, load pc from bus
//   ret        pop stack top into pc
//   pc_out     current pc
//   sp         number of occupied stack entries
//   stk_full   sp == DEPTH
//   stk_empty  sp == 0
//   stk_err    sticky overflow/underflow flag, cleared only by rst
module program_counter_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  inout  wire  [WIDTH-1:0]           bus,
  input  logic                       co,
  input  logic                       ce,
  input  logic                       updown,
  input  logic                       jmp,
  input  logic                       rel,
  input  logic                       call,
  input  logic                       ret,
  output logic [WIDTH-1:0]           pc_out,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       stk_full,
  output logic                       stk_empty,
  output logic                       stk_err
);

  localparam int SPW = $clog2(DEPTH+1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NE  = 2**AW;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_RET,
    CMD_CALL,
    CMD_JMP,
    CMD_REL,
    CMD_CNT
  } cmd_e;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] stk_q [NE];

  logic             push;
  logic [AW-1:0]    push_idx;
  logic [AW-1:0]    pop_idx;
  logic [WIDTH-1:0] ret_addr;
  logic [WIDTH-1:0] bus_in;
  cmd_e             cmd;

  assign bus    = co ? pc_q : {WIDTH{1'bz}};
  assign bus_in = bus;

  assign pc_out    = pc_q;
  assign sp        = sp_q;
  assign stk_full  = full_q;
  assign stk_empty = empty_q;
  assign stk_err   = err_q;

  assign push_idx = sp_q[AW-1:0];
  assign pop_idx  = AW'(sp_q - SPW'(1));
  assign ret_addr = pc_q + WIDTH'(1);

  // Only the highest-priority request is honoured each edge.
  always_comb begin
    cmd = CMD_NONE;
    if (ret)       cmd = CMD_RET;
    else if (call) cmd = CMD_CALL;
    else if (jmp)  cmd = CMD_JMP;
    else if (rel)  cmd = CMD_REL;
    else if (ce)   cmd = CMD_CNT;
  end

  // A refused call/ret only raises the error flag; it never falls
  // through to a lower-priority request.
  always_comb begin
    pc_d  = pc_q;
    sp_d  = sp_q;
    err_d = err_q;
    push  = 1'b0;
    unique case (cmd)
      CMD_RET: begin
        if (sp_q == '0) begin
          err_d = 1'b1;
        end else begin
          pc_d = stk_q[pop_idx];
          sp_d = sp_q - SPW'(1);
        end
      end
      CMD_CALL: begin
        if (sp_q == SPW'(DEPTH)) begin
          err_d = 1'b1;
        end else begin
          push = 1'b1;
          pc_d = bus_in;
          sp_d = sp_q + SPW'(1);
        end
      end
      CMD_JMP: pc_d = bus_in;
      // Same-width add is the sign-extended add modulo 2^WIDTH.
      CMD_REL: pc_d = pc_q + bus_in;
      CMD_CNT: pc_d = updown ? pc_q + WIDTH'(1)
                             : pc_q - WIDTH'(1);
      CMD_NONE: pc_d = pc_q;
      default: pc_d = pc_q;
    endcase
    full_d  = (sp_d == SPW'(DEPTH));
    empty_d = (sp_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      sp_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      err_q   <= err_d;
    end
  end

  // Entries are not cleared; sp gates visibility after reset.
  always_ff @(posedge clk) begin
    if (push && !rst) stk_q[push_idx] <= ret_addr;
  end

endmodule

// File: tb/tb_program_counter_stack.sv
// Self-checking bench for program_counter_stack: directed scenarios
// plus random commands compared against a queue-based reference model.
module tb_program_counter_stack;
  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 0;
  logic         rst = 0;
  logic         co = 0, ce = 0, updown = 0;
  logic         jmp = 0, rel = 0, call = 0, ret = 0;
  logic         drv_en = 0;
  logic [W-1:0] drv = '0;
  wire  [W-1:0] bus;
  logic [W-1:0] pc_out;
  logic [2:0]   sp;
  logic         stk_full, stk_empty, stk_err;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_pc;
  logic         m_err;
  logic [W-1:0] m_stk [$];

  assign bus = drv_en ? drv : {W{1'bz}};

  always #5 clk = ~clk;

  program_counter_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .bus(bus), .co(co), .ce(ce),
    .updown(updown), .jmp(jmp), .rel(rel), .call(call), .ret(ret),
    .pc_out(pc_out), .sp(sp), .stk_full(stk_full),
    .stk_empty(stk_empty), .stk_err(stk_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [W-1:0] b;
    b = co ? m_pc : drv;
    if (rst) begin
      m_pc = '0; m_err = 0; m_stk.delete();
    end else if (ret) begin
      if (m_stk.size() == 0) m_err = 1;
      else m_pc = m_stk.pop_back();
    end else if (call) begin
      if (m_stk.size() == D) m_err = 1;
      else begin
        m_stk.push_back(W'(m_pc + 1));
        m_pc = b;
      end
    end else if (jmp) m_pc = b;
    else if (rel) m_pc = W'(m_pc + b);
    else if (ce) m_pc = updown ? W'(m_pc + 1) : W'(m_pc - 1);
  endtask

  task automatic cmp_model();
    chk("pc", 32'(pc_out), 32'(m_pc));
    chk("sp", 32'(sp), 32'(m_stk.size()));
    chk("full", 32'(stk_full), 32'(m_stk.size() == D));
    chk("empty", 32'(stk_empty), 32'(m_stk.size() == 0));
    chk("err", 32'(stk_err), 32'(m_err));
    if (co) chk("bus", 32'(bus), 32'(m_pc));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    cmp_model();
  endtask

  task automatic set_in(input logic r, input logic c, input logic j,
                        input logic rl, input logic e, input logic ud,
                        input logic o, input logic [W-1:0] v);
    ret = r; call = c; jmp = j; rel = rl; ce = e; updown = ud;
    co = o; drv_en = !o; drv = v;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 8'h00);
    #2 rst = 1;
    m_pc = '0; m_err = 0; m_stk.delete();
    #1 cmp_model();
    #2 rst = 0;
  endtask

  initial begin
    m_pc = '0; m_err = 0;
    @(negedge clk);
    // commands held during reset must be ignored
    rst = 1;
    set_in(0, 1, 1, 0, 1, 1, 0, 8'h77);
    @(posedge clk); #1;
    chk("rst_pc", 32'(pc_out), 32'h0);
    chk("rst_sp", 32'(sp), 32'h0);
    chk("rst_empty", 32'(stk_empty), 32'h1);
    chk("rst_full", 32'(stk_full), 32'h0);
    chk("rst_err", 32'(stk_err), 32'h0);
    set_in(0, 0, 0, 0, 0, 0, 0, 8'h00);
    #2 rst = 0;

    set_in(0, 0, 0, 0, 1, 1, 0, 8'h00);
    for (int i = 1; i <= 257; i++) begin
      cyc();
      if (i == 255) chk("cnt255", 32'(pc_out), 32'hFF);
      if (i == 256) chk("wrap0", 32'(pc_out), 32'h00);
      if (i == 257) chk("wrap1", 32'(pc_out), 32'h01);
    end
    set_in(0, 0, 0, 0, 1, 0, 0, 8'h00);
    cyc(); chk("dn0", 32'(pc_out), 32'h00);
    cyc(); chk("dnFF", 32'(pc_out), 32'hFF);

    set_in(0, 0, 0, 0, 0, 0, 0, 8'h5A);
    #1 chk("bus_hiz", 32'(bus), 32'h5A);
    set_in(0, 0, 1, 0, 0, 0, 0, 8'h2A); cyc();
    set_in(0, 0, 0, 0, 0, 0, 1, 8'h00);
    #1 chk("bus_drv", 32'(bus), 32'h2A);
    set_in(0, 0, 1, 0, 0, 0, 0, 8'h80); cyc();
    chk("jmp80", 32'(pc_out), 32'h80);
    set_in(0, 0, 0, 1, 0, 0, 0, 8'hFE); cyc();
    chk("rel7E", 32'(pc_out), 32'h7E);
    set_in(0, 0, 1, 0, 0, 0, 1, 8'h00); cyc();
    chk("co_reload", 32'(pc_out), 32'h7E);

    set_in(0, 0, 1, 0, 0, 0, 0, 8'h10); cyc();
    set_in(0, 1, 0, 0, 0, 0, 0, 8'h40); cyc();
    chk("call_pc", 32'(pc_out), 32'h40);
    chk("call_sp", 32'(sp), 32'h1);
    set_in(0, 0, 0, 0, 1, 1, 0, 8'h00);
    repeat (3) cyc();
    chk("ce3", 32'(pc_out), 32'h43);
    set_in(1, 0, 0, 0, 0, 0, 0, 8'h00); cyc();
    chk("ret_pc", 32'(pc_out), 32'h11);
    chk("ret_sp", 32'(sp), 32'h0);
    chk("ret_empty", 32'(stk_empty), 32'h1);

    set_in(0, 0, 1, 0, 0, 0, 0, 8'h00); cyc();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1, 0, 0, 0, 0, 0, W'(8'h20 + 8'h10 * i));
      cyc();
    end
    chk("ovf_full", 32'(stk_full), 32'h1);
    set_in(0, 1, 1, 0, 1, 1, 0, 8'h99); cyc();
    chk("ovf_pc", 32'(pc_out), 32'h50);
    chk("ovf_sp", 32'(sp), 32'h4);
    chk("ovf_err", 32'(stk_err), 32'h1);
    set_in(1, 0, 0, 0, 0, 0, 0, 8'h00);
    cyc(); chk("lifo0", 32'(pc_out), 32'h41);
    cyc(); chk("lifo1", 32'(pc_out), 32'h31);
    cyc(); chk("lifo2", 32'(pc_out), 32'h21);
    cyc(); chk("lifo3", 32'(pc_out), 32'h01);

    do_reset();
    set_in(1, 0, 0, 0, 1, 1, 0, 8'h00); cyc();
    chk("udf_pc", 32'(pc_out), 32'h00);
    chk("udf_err", 32'(stk_err), 32'h1);
    set_in(0, 1, 1, 0, 0, 0, 0, 8'h33); cyc();
    chk("cj_pc", 32'(pc_out), 32'h33);
    chk("cj_sp", 32'(sp), 32'h1);
    do_reset();
    chk("mid_pc", 32'(pc_out), 32'h00);
    chk("mid_err", 32'(stk_err), 32'h0);
    set_in(1, 0, 0, 0, 0, 0, 0, 8'h00); cyc();
    chk("post_rst_udf", 32'(stk_err), 32'h1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        set_in($urandom_range(0, 6) == 0, $urandom_range(0, 5) == 0,
               $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
               1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
               W'($urandom));
        cyc();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
